// File: rtl/button_events_if.sv
// Button event bus: debounced level in, one-cycle event pulses and status out.
// release/repeat are SystemVerilog keywords, so those pulses carry a _pulse suffix.
interface button_events_if;
    logic       ButtonIn;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] event_cnt;

    modport master (
        output ButtonIn,
        input  press, release_pulse, long_press, repeat_pulse, held, event_cnt
    );

    modport slave (
        input  ButtonIn,
        output press, release_pulse, long_press, repeat_pulse, held, event_cnt
    );
endinterface

// File: rtl/button_events.sv
// Purpose: turns a clean button level into press/release/long-press/auto-repeat pulses plus an 8-bit event count.
// Latency: every output is registered, one cycle after the edge that samples the cause; no backpressure (pulses are fire-and-forget).
// Option: BUTTON_EVENTS_AUTOREPEAT_EN enables repeat pulses while in the long-hold state.
module button_events #(
    parameter int CW           = 25,
    parameter int LONG_COUNT   = 25000000,
    parameter int REPEAT_COUNT = 5000000
) (
    input  logic           clk,
    input  logic           rst,
    button_events_if.slave bus
);

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_COUNT - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          btn_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          repeat_q;
    logic          held_q;
    logic [7:0]    event_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_q       <= 1'b1;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            event_cnt_q <= 8'd0;
        end else begin
            btn_q     <= bus.ButtonIn;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ButtonIn && !btn_q) begin
                        state       <= PRESSED;
                        press_q     <= 1'b1;
                        held_q      <= 1'b1;
                        cnt         <= '0;
                        event_cnt_q <= event_cnt_q + 8'd1;
                    end
                end
                PRESSED: begin
                    // Release is tested first so it wins over a threshold hit on the same edge.
                    if (!bus.ButtonIn) begin
                        state     <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state  <= HELD;
                        long_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!bus.ButtonIn) begin
                        state     <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt       <= '0;
                    end else if (AUTOREPEAT) begin
                        if (cnt == REPEAT_LAST) begin
                            repeat_q    <= 1'b1;
                            cnt         <= '0;
                            event_cnt_q <= event_cnt_q + 8'd1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    held_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.press         = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_press    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;
    assign bus.event_cnt     = event_cnt_q;

endmodule

// File: tb/tb_button_events.sv
// Randomised and directed bench for button_events with a hold-age reference model and scoreboard queue.
module tb_button_events;
    localparam int L = 8;
    localparam int R = 4;

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct packed {
        logic       press;
        logic       rel;
        logic       lp;
        logic       rp;
        logic       held;
        logic [7:0] evt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    button_events_if bus();

    button_events #(
        .CW(8),
        .LONG_COUNT(L),
        .REPEAT_COUNT(R)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle_no = 0;

    // Reference model: tracks how long the button has been held since the accepted press.
    bit         m_prev   = 1'b1;
    bit         m_active = 1'b0;
    int         m_age    = 0;
    logic [7:0] m_evt    = 8'd0;

    task automatic cyc(input bit r, input bit b);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.ButtonIn = b;
        e = '0;
        if (r) begin
            m_prev   = 1'b1;
            m_active = 1'b0;
            m_age    = 0;
            m_evt    = 8'd0;
        end else begin
            if (!m_active) begin
                if (b && !m_prev) begin
                    m_active = 1'b1;
                    m_age    = 0;
                    e.press  = 1'b1;
                    m_evt    = m_evt + 8'd1;
                end
            end else if (!b) begin
                m_active = 1'b0;
                e.rel    = 1'b1;
            end else begin
                m_age = m_age + 1;
                if (m_age == L) begin
                    e.lp = 1'b1;
                end else if (AR && m_age > L && ((m_age - L) % R) == 0) begin
                    e.rp  = 1'b1;
                    m_evt = m_evt + 8'd1;
                end
            end
            m_prev = b;
        end
        e.held = m_active;
        e.evt  = m_evt;
        q.push_back(e);
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, b);
    endtask

    // Monitor: compares every registered output cycle against the queued expectation.
    initial begin
        exp_t a;
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (q.size() != 0) begin
                x = q.pop_front();
                a.press = bus.press;
                a.rel   = bus.release_pulse;
                a.lp    = bus.long_press;
                a.rp    = bus.repeat_pulse;
                a.held  = bus.held;
                a.evt   = bus.event_cnt;
                checks++;
                if (a !== x) begin
                    failures++;
                    $display("FAIL outputs cycle %0d: got press=%b release=%b long=%b repeat=%b held=%b cnt=%0d, expected press=%b release=%b long=%b repeat=%b held=%b cnt=%0d",
                             cycle_no, a.press, a.rel, a.lp, a.rp, a.held, a.evt,
                             x.press, x.rel, x.lp, x.rp, x.held, x.evt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ButtonIn = 1'b1;

        // Button already held through reset: no press until it is seen low.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        hold(1'b1, 20);
        hold(1'b0, 3);

        // Long hold with auto-repeat.
        hold(1'b1, 21);
        hold(1'b0, 3);

        // Release exactly at the long-press threshold.
        hold(1'b1, L);
        hold(1'b0, 3);

        // Minimum press followed by a re-press two cycles later.
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 3);

        // Counter wrap over 257 short presses.
        for (int i = 0; i < 257; i++) begin
            hold(1'b1, 1);
            hold(1'b0, 1);
        end
        hold(1'b0, 2);

        // Reset while held: no release, and no press until low then high.
        hold(1'b1, 10);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        hold(1'b1, 5);
        hold(1'b0, 1);
        hold(1'b1, 3);
        hold(1'b0, 2);

        // Random runs with occasional resets.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) cyc(1'b1, 1'($urandom_range(0, 1)));
            end
            hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
        end
        hold(1'b0, 2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/button_events.md
# button_events

Turns the debounced button level into one-cycle event pulses for the VGA control logic: press, release, long-press, and optional auto-repeat while held. It also keeps a wrapping 8-bit count of accepted press and repeat events. It sits directly after the `antirrebote` debouncer of each button and feeds the cursor/colour control FSMs. It adds no filtering, so its input must already be clean and synchronous to `clk`.

## Interface
- `CW`, 25: width of the internal cycle counter; `LONG_COUNT` and `REPEAT_COUNT` must fit in `CW` bits.
- `LONG_COUNT`, 25000000: cycles the button must stay held before `long_press` fires (0.5 s at 50 MHz); minimum 2.
- `REPEAT_COUNT`, 5000000: cycles between `repeat` pulses once in the long-hold state; minimum 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `ButtonIn` in 1: debounced button level, 1 = pressed.
- `press` out 1: one-cycle pulse on an accepted press.
- `release` out 1: one-cycle pulse when the button goes low after an accepted press.
- `long_press` out 1: one-cycle pulse when the hold reaches `LONG_COUNT`.
- `repeat` out 1: one-cycle auto-repeat pulse.
- `held` out 1: high while the FSM is not in IDLE.
- `event_cnt` out 8: count of `press` plus `repeat` pulses; wraps from 255 to 0.

## Operation
- Input stage: `btn_q` is the registered copy of `ButtonIn` from the previous edge. A rising edge means `ButtonIn`=1 and `btn_q`=0.
- Reset: `btn_q` resets to 1, so a button already held during or after reset gives no `press` until it has been seen low.
- FSM states:
  - IDLE: `held`=0. A rising edge moves to PRESSED, asserts `press`, and clears `cnt`.
  - PRESSED: counts cycles while `ButtonIn`=1.
    - When `cnt`==`LONG_COUNT`-1: move to HELD, assert `long_press`, clear `cnt`.
    - Otherwise `cnt`+1.
  - HELD: counts cycles while `ButtonIn`=1.
    - When `cnt`==`REPEAT_COUNT`-1: assert `repeat`, clear `cnt`.
    - Otherwise `cnt`+1.
- Release: `ButtonIn`=0 seen in PRESSED or HELD moves to IDLE, asserts `release`, and clears `cnt`.
- Release at a threshold: release wins. No `long_press` or `repeat` is issued on that edge.
- `event_cnt` increments by 1 on each `press` or `repeat` pulse. `press` and `repeat` never occur on the same edge.
- All pulse outputs are registered and are high for exactly one cycle.
- Reset values: `press`, `release`, `long_press`, `repeat`, `held` = 0; `event_cnt` = 0; `cnt` = 0; state IDLE; `btn_q` = 1.
- Reset mid-operation: `rst` dominates on any edge. No `release` is issued for a press aborted by reset.

## Timing
- Edge E0 is the first edge that samples a rising edge.
- `press` is high in the cycle after E0, and `held` rises at the same time.
- `long_press` is registered at edge E0+`LONG_COUNT`, provided `ButtonIn` stays 1.
- The first `repeat` is at E0+`LONG_COUNT`+`REPEAT_COUNT`, then one every `REPEAT_COUNT` edges.
- Release sampled at edge Er: `release` is high in the cycle after Er, and `held` falls at the same time.
- Back-to-back press: a press may be accepted at Er+1 if `ButtonIn` returns high there, because `btn_q`=0 after Er.
- The minimum press is a 1-cycle high. It yields `press` and then `release` one cycle apart.

## Configuration
- Macro `BUTTON_EVENTS_AUTOREPEAT_EN`.
- Defined: HELD performs the repeat counting described above.
- Undefined:
  - HELD does not count; `cnt` stays 0.
  - `repeat` is tied to 0.
  - `event_cnt` counts only `press` pulses.
  - `long_press`, `release` and `held` behave identically.

## Test plan
Bench uses `LONG_COUNT`=8, `REPEAT_COUNT`=4, macro defined unless stated.
- Reset held 3 cycles with `ButtonIn`=1, then `rst`=0 and the button kept high for 20 cycles -> no pulses; `held`=0; `event_cnt`=0.
- `ButtonIn` 0->1 sampled at edge E0 and held 20 cycles -> pulses as follows, then `release` one cycle after the button goes low:
  - `press` at E0;
  - `long_press` at E0+8;
  - `repeat` at E0+12, E0+16, E0+20;
  - `event_cnt`=4.
- Release sampled exactly at E0+8 -> `release` only, no `long_press`; `held` drops one cycle after that edge.
- 1-cycle high pulse followed by a high again 2 cycles later -> `press`, `release`, `press`; `event_cnt`=2.
- 256 short presses -> `event_cnt` wraps to 0; 257th press -> 1.
- Macro undefined, button held 20 cycles -> `long_press` at E0+8 and no `repeat`; `event_cnt`=1.
- `rst` asserted at E0+10 while held -> all outputs 0 the next cycle and no `release`; after reset no `press` until the button has gone low and high again.
